conv_seq_ctrl: RTL and testbench

- Address and control sequencer for one convolution layer pass.
- Drives the source-buffer read port (exec, ia) and the destination-buffer write/accumulate port (outr, accr, oa).
- Also drives the MAC accumulator clear (clr).
- Walks output pixels and, for each pixel, every input-channel × kernel tap; then issues one write-back per pixel after the MAC pipeline latency.

---
 rtl/conv_seq_if.sv | 13 +
 rtl/conv_seq_ctrl.sv | 118 +++++++++++
 tb/tb_conv_seq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/conv_seq_if.sv
// conv_seq_if: source-read and destination-write/accumulate port bundle of the convolution sequencer
interface conv_seq_if #(
  parameter int AW = 12
);
  logic exec;
  logic clr;
  logic [AW:0] ia;
  logic outr;
  logic accr;
  logic [AW:0] oa;
  modport master (output exec, clr, ia, outr, accr, oa);
  modport slave (input exec, clr, ia, outr, accr, oa);
endinterface

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: address/control sequencer for one convolution layer pass; CONV_SEQ_STALL_EN adds a stall input
module conv_seq_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int AW = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic [2:0] cfg_fs,
  input  logic [5:0] cfg_ih,
  input  logic [5:0] cfg_ic,
  input  logic cfg_sbank,
  input  logic cfg_obank,
  input  logic cfg_acc,
  output logic busy,
  output logic done,
  output logic err,
`ifdef CONV_SEQ_STALL_EN
  input  logic stall,
`endif
  conv_seq_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam logic [AW-1:0] ONE = 1;
  logic [1:0] st;
  logic [2:0] fsm1, kx, ky;
  logic [5:0] ih, icm1, ohm1, c, ox, oy;
  logic [AW-1:0] ihh, pb, cb, rb, a, pix, np, ncb;
  logic sbank, obank, acc, bad, bad_cfg, hold, go, kl, fin;
  logic [11:0] sq;
  logic [17:0] vol;
  logic [PIPE_LAT-1:0] dl_v;
  logic [AW-1:0] dl_i [PIPE_LAT];
`ifdef CONV_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif
  assign sq = {6'd0, cfg_ih} * {6'd0, cfg_ih};
  assign vol = {6'd0, sq} * {12'd0, cfg_ic};
  assign bad_cfg = cfg_fs == 3'd0 || cfg_ih == 6'd0 || cfg_ic == 6'd0 || {3'd0, cfg_fs} > cfg_ih || vol > 18'd4096;
  assign go = st == RUN && !hold;
  assign kl = kx == fsm1 && ky == fsm1 && c == icm1;
  assign fin = kl && ox == ohm1 && oy == ohm1;
  // next pixel origin: step right, or jump to the start of the next output row (ih - oh + 1 = fs)
  always_comb begin
    np = ox == ohm1 ? pb + AW'(fsm1) + ONE : pb + ONE;
    ncb = cb + ihh;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      {bad, sbank, obank, acc} <= '0;
      {fsm1, ih, icm1, ohm1, ihh} <= '0;
      {kx, ky, c, ox, oy} <= '0;
      {pb, cb, rb, a, pix} <= '0;
      dl_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dl_i[i] <= '0;
    end else begin
      dl_v <= (dl_v << 1) | PIPE_LAT'(go && kl);
      dl_i[0] <= pix;
      for (int i = 1; i < PIPE_LAT; i++) dl_i[i] <= dl_i[i-1];
      if (st == IDLE && run) begin
        st <= bad_cfg ? DONE : RUN;
        bad <= bad_cfg;
        sbank <= cfg_sbank;
        obank <= cfg_obank;
        acc <= cfg_acc;
        fsm1 <= cfg_fs - 3'd1;
        ih <= cfg_ih;
        icm1 <= cfg_ic - 6'd1;
        ohm1 <= cfg_ih - {3'd0, cfg_fs};
        ihh <= AW'(sq);
        {kx, ky, c, ox, oy} <= '0;
        {pb, cb, rb, a, pix} <= '0;
      end else if (st == DONE) begin
        st <= IDLE;
      end else if (st == DRAIN) begin
        st <= ~|(dl_v << 1) ? DONE : DRAIN;
      end else if (go) begin
        st <= fin ? DRAIN : RUN;
        if (kx != fsm1) begin
          kx <= kx + 3'd1;
          a <= a + ONE;
        end else if (ky != fsm1) begin
          kx <= '0;
          ky <= ky + 3'd1;
          rb <= rb + AW'(ih);
          a <= rb + AW'(ih);
        end else if (c != icm1) begin
          {kx, ky} <= '0;
          c <= c + 6'd1;
          cb <= ncb;
          rb <= ncb + pb;
          a <= ncb + pb;
        end else begin
          {kx, ky, c} <= '0;
          cb <= '0;
          pix <= pix + ONE;
          ox <= ox == ohm1 ? 6'd0 : ox + 6'd1;
          oy <= ox == ohm1 ? oy + 6'd1 : oy;
          pb <= np;
          rb <= np;
          a <= np;
        end
      end
    end
  end
  assign bus.exec = go;
  assign bus.clr = go && kx == 3'd0 && ky == 3'd0 && c == 6'd0;
  assign bus.ia = {sbank, a};
  assign bus.outr = dl_v[PIPE_LAT-1];
  assign bus.accr = dl_v[PIPE_LAT-1] && acc;
  assign bus.oa = dl_v[PIPE_LAT-1] ? {obank, dl_i[PIPE_LAT-1]} : '0;
  assign busy = st == RUN || st == DRAIN;
  assign done = st == DONE;
  assign err = done && bad;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: table-driven check of conv_seq_ctrl plus reset-abort and stall sequences
module tb_conv_seq_ctrl;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, stall = 1'b0;
  logic [2:0] cfg_fs = '0;
  logic [5:0] cfg_ih = '0, cfg_ic = '0;
  logic cfg_sbank = 1'b0, cfg_obank = 1'b0, cfg_acc = 1'b0;
  logic busy, done, err;
  int total = 0, bad = 0;
  conv_seq_if #(.AW(12)) bus();
  conv_seq_ctrl #(.PIPE_LAT(4), .AW(12)) dut (
    .clk(clk), .reset(reset), .run(run),
    .cfg_fs(cfg_fs), .cfg_ih(cfg_ih), .cfg_ic(cfg_ic),
    .cfg_sbank(cfg_sbank), .cfg_obank(cfg_obank), .cfg_acc(cfg_acc),
    .busy(busy), .done(done), .err(err),
`ifdef CONV_SEQ_STALL_EN
    .stall(stall),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    int fs, ih, ic, sb, ob, ac, er, ne, no, nc, ias, oas, fo, d;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t t, input int s0, input int sn);
    logic [12:0] q[$];
    int ne = 0, no = 0, na = 0, nc = 0, ias = 0, oas = 0, fo = 0, fe = 0;
    int da = 0, ern = 0, nb = 0, seq = 0, oz = 0, idx = 0;
    int oh = t.ih - t.fs + 1;
    if (t.er == 0)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < oh; ox++)
          for (int c = 0; c < t.ic; c++)
            for (int ky = 0; ky < t.fs; ky++)
              for (int kx = 0; kx < t.fs; kx++)
                q.push_back({1'(t.sb), 12'(c * t.ih * t.ih + (oy + ky) * t.ih + ox + kx)});
    @(negedge clk);
    cfg_fs = 3'(t.fs); cfg_ih = 6'(t.ih); cfg_ic = 6'(t.ic);
    cfg_sbank = 1'(t.sb); cfg_obank = 1'(t.ob); cfg_acc = 1'(t.ac);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cfg_fs = 3'($urandom); cfg_ih = 6'($urandom); cfg_ic = 6'($urandom);
    cfg_sbank = ~cfg_sbank; cfg_obank = ~cfg_obank; cfg_acc = ~cfg_acc;
    for (int cyc = 1; cyc < 5000 && da == 0; cyc++) begin
      stall = cyc >= s0 && cyc < s0 + sn;
      #1;
      if (bus.exec) begin
        ne++;
        if (fe == 0) fe = cyc;
        ias += int'(bus.ia[11:0]);
        if (q.size() == 0 || bus.ia != q.pop_front()) seq++;
      end
      if (bus.clr) nc++;
      if (bus.outr) begin
        no++;
        if (fo == 0) fo = cyc;
        oas += int'(bus.oa[11:0]);
        if (bus.oa != {1'(t.ob), 12'(idx)}) seq++;
        idx++;
      end else if (bus.oa != 13'd0) oz++;
      if (bus.accr) na++;
      if (busy) nb++;
      if (err) ern++;
      if (done) da = cyc;
      @(negedge clk);
    end
    stall = 1'b0;
    chk($sformatf("err fs=%0d ih=%0d ic=%0d", t.fs, t.ih, t.ic), ern, t.er);
    chk("exec_count", ne, t.ne);
    chk("outr_count", no, t.no);
    chk("accr_count", na, t.ac != 0 ? t.no : 0);
    chk("clr_count", nc, t.nc);
    chk("ia_sum", ias, t.ias);
    chk("oa_sum", oas, t.oas);
    chk("addr_order_errs", seq, 0);
    chk("oa_idle_nonzero", oz, 0);
    chk("first_exec_cycle", fe, t.er != 0 ? 0 : 1);
    chk("first_outr_cycle", fo, t.fo);
    chk("done_cycle", da, t.d);
    chk("busy_cycles", nb, t.er != 0 ? 0 : t.d - 1);
  endtask
  initial begin
    v[0]  = '{1, 2, 1, 1, 0, 0, 0, 4, 4, 4, 6, 6, 5, 9};
    v[1]  = '{2, 3, 1, 0, 0, 0, 0, 16, 4, 4, 64, 6, 8, 21};
    v[2]  = '{2, 3, 2, 0, 1, 1, 0, 32, 4, 4, 272, 6, 12, 37};
    v[3]  = '{4, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    v[4]  = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 5, 6};
    v[5]  = '{3, 3, 1, 0, 0, 0, 0, 9, 1, 1, 36, 0, 13, 14};
    v[6]  = '{1, 3, 1, 0, 1, 0, 0, 9, 9, 9, 36, 36, 5, 14};
    v[7]  = '{1, 32, 4, 0, 0, 1, 0, 4096, 1024, 1024, 8386560, 523776, 8, 4101};
    v[8]  = '{1, 32, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    v[9]  = '{0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    v[10] = '{2, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    v[11] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    v[12] = '{5, 63, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    repeat (3) @(negedge clk);
    chk("reset_outputs", longint'({busy, done, err, bus.exec, bus.clr, bus.outr, bus.accr, bus.ia, bus.oa}), 0);
    reset = 1'b0;
    foreach (v[i]) run_vec(v[i], 0, 0);
    begin
      int nd = 0, nx = 0;
      @(negedge clk);
      cfg_fs = 3'd2; cfg_ih = 6'd3; cfg_ic = 6'd2; cfg_acc = 1'b1; cfg_obank = 1'b1; cfg_sbank = 1'b1;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrun_reset_outputs", longint'({busy, done, err, bus.exec, bus.clr, bus.outr, bus.accr, bus.ia, bus.oa}), 0);
      repeat (40) begin
        if (done) nd++;
        if (bus.exec || bus.outr || busy) nx++;
        @(negedge clk);
      end
      chk("midrun_reset_done_pulses", nd, 0);
      chk("midrun_reset_activity", nx, 0);
    end
    run_vec(v[4], 0, 0);
`ifdef CONV_SEQ_STALL_EN
    begin
      vec_t s = v[1];
      s.d = 24;
      run_vec(s, 6, 3);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
